// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmit FSM states and frame sizing.
package uart_pkg;

   localparam int DATA_BITS = 8;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_ODD  = 2'b01;
   localparam logic [1:0] PARITY_EVEN = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // 2'b11 is treated like PARITY_NONE, so only the two real encodings add a bit.
   function automatic logic has_parity(input logic [1:0] ptype);
      return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
   endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity bit for one UART byte; outputs 0 when no parity is selected.
module uart_parity_gen
   import uart_pkg::*;
(
   input  logic [DATA_BITS-1:0] data,
   input  logic [1:0]           parity_type,
   output logic                 parity_bit
);

   always_comb begin
      parity_bit = 1'b0;
      case (parity_type)
         PARITY_ODD:  parity_bit = ~^data;
         PARITY_EVEN: parity_bit = ^data;
         default:     parity_bit = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, 8 data bits LSB first, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [1:0]           parity_type,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
`ifdef UART_TX_TWO_STOP_EN
   localparam logic STOP_LAST = 1'b1;
`else
   localparam logic STOP_LAST = 1'b0;
`endif

   tx_state_t            state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [2:0]           bit_idx, bit_idx_n;
   logic                 stop_idx, stop_idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [DATA_BITS-1:0] data_q, data_n;
   logic [1:0]           ptype_q, ptype_n;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 parity_bit;
   logic                 cnt_last;

   // Parity always comes from the byte and type captured at acceptance.
   uart_parity_gen u_parity (
      .data        (data_q),
      .parity_type (ptype_q),
      .parity_bit  (parity_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shift    <= '0;
         data_q   <= '0;
         ptype_q  <= PARITY_NONE;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         shift    <= shift_n;
         data_q   <= data_n;
         ptype_q  <= ptype_n;
         tx_q     <= tx_d;
         done_q   <= done_d;
      end
   end

   assign cnt_last = (cnt == CNT_LAST);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      shift_n    = shift;
      data_n     = data_q;
      ptype_n    = ptype_q;

      if (state == IDLE) begin
         cnt_n = '0;
         if (s_valid) begin
            data_n  = s_data;
            shift_n = s_data;
            ptype_n = parity_type;
            state_n = START;
         end
      end else if (!cnt_last) begin
         cnt_n = cnt + CNT_W'(1);
      end else begin
         cnt_n = '0;
         case (state)
            START: begin
               bit_idx_n = '0;
               state_n   = DATA;
            end
            DATA: begin
               shift_n = shift >> 1;
               if (bit_idx == BIT_LAST) begin
                  stop_idx_n = 1'b0;
                  state_n    = has_parity(ptype_q) ? PARITY : STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end
            PARITY: begin
               stop_idx_n = 1'b0;
               state_n    = STOP;
            end
            STOP: begin
               if (stop_idx == STOP_LAST) begin
                  state_n = IDLE;
               end else begin
                  stop_idx_n = ~stop_idx;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // The line level and done pulse are registered from the upcoming state so tx never glitches.
   always_comb begin
      tx_d = 1'b1;
      case (state_n)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_n[0];
         PARITY:  tx_d = parity_bit;
         default: tx_d = 1'b1;
      endcase
      done_d = (state_n == STOP) && (cnt_n == CNT_LAST) && (stop_idx_n == STOP_LAST);
   end

   assign tx      = tx_q;
   assign done    = done_q;
   assign busy    = (state != IDLE);
   assign s_ready = (state == IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: the driver queues hand-computed frames, a monitor checks the line.
module tb_uart_tx_ctrl;

   localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
   localparam int LEN_PAR   = 48;
   localparam int LEN_NOPAR = 44;
`else
   localparam int LEN_PAR   = 44;
   localparam int LEN_NOPAR = 40;
`endif

   typedef struct {
      logic [7:0] data;
      bit         has_par;
      bit         par;
      int         len;
      int         gap;
      bit         aborted;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [1:0] parity_type;
   logic       tx;
   logic       busy;
   logic       done;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   bit   in_frame = 0;
   int   frame_len = 0;
   int   done_cnt = 0;
   int   done_at = 0;
   int   idle_cnt = 0;
   int   frame_gap = 0;
   int   stray_done = 0;
   logic tx_samples[$];

   uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .reset       (reset),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .parity_type (parity_type),
      .tx          (tx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic expTx(input exp_t e, input int c);
      int b;
      b = c / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return e.data[b-1];
      if (b == 9 && e.has_par) return e.par;
      return 1'b1;
   endfunction

   // Collect each frame cycle by cycle while busy, then judge it against the next queued expectation.
   always @(negedge clk) begin
      if (done === 1'b1 && busy !== 1'b1) stray_done++;
      if (busy === 1'b1) begin
         if (!in_frame) begin
            in_frame  = 1;
            frame_len = 0;
            done_cnt  = 0;
            done_at   = 0;
            frame_gap = idle_cnt;
            tx_samples.delete();
         end
         tx_samples.push_back(tx);
         frame_len++;
         if (done === 1'b1) begin
            done_cnt++;
            done_at = frame_len;
         end
      end else begin
         if (in_frame) begin
            in_frame = 0;
            if (sb.size() == 0) begin
               checkOutput("unexpected frame", 1, 0);
            end else begin
               exp_t e;
               int   mism;
               int   n;
               e = sb.pop_front();
               mism = 0;
               n = (frame_len < e.len) ? frame_len : e.len;
               for (int c = 0; c < n; c++)
                  if (tx_samples[c] !== expTx(e, c)) mism++;
               checkOutput($sformatf("frame %02h length", e.data), frame_len, e.len);
               checkOutput($sformatf("frame %02h bit errors", e.data), mism, 0);
               checkOutput($sformatf("frame %02h done pulses", e.data), done_cnt, e.aborted ? 0 : 1);
               if (!e.aborted)
                  checkOutput($sformatf("frame %02h done cycle", e.data), done_at, e.len);
               if (e.gap >= 0)
                  checkOutput($sformatf("frame %02h idle gap", e.data), frame_gap, e.gap);
            end
            idle_cnt = 0;
         end
         idle_cnt++;
      end
   end

   task automatic applyStimulus(input logic [7:0] d, input logic [1:0] pt, input exp_t e, input bit hold);
      int n;
      @(negedge clk);
      s_valid     = 1'b1;
      s_data      = d;
      parity_type = pt;
      n = 0;
      while (s_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (s_ready !== 1'b1) begin
         checkOutput("handshake timeout", 0, 1);
         s_valid = 1'b0;
         return;
      end
      sb.push_back(e);
      @(negedge clk);
      if (!hold) s_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) checkOutput("idle timeout", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      exp_t e;
      reset       = 1'b1;
      s_valid     = 1'b0;
      s_data      = 8'h00;
      parity_type = 2'b00;
      repeat (2) @(negedge clk);
      checkOutput("reset tx", tx, 1);
      checkOutput("reset s_ready", s_ready, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      e = '{data: 8'hA5, has_par: 1, par: 0, len: LEN_PAR, gap: -1, aborted: 0};
      applyStimulus(8'hA5, 2'b10, e, 0);
      waitIdle();

      // Live inputs are scrambled right after acceptance; the frame must still carry 0xA5 with odd parity.
      e = '{data: 8'hA5, has_par: 1, par: 1, len: LEN_PAR, gap: -1, aborted: 0};
      applyStimulus(8'hA5, 2'b01, e, 0);
      s_data      = 8'h3C;
      parity_type = 2'b00;
      waitIdle();

      e = '{data: 8'h00, has_par: 0, par: 0, len: LEN_NOPAR, gap: -1, aborted: 0};
      applyStimulus(8'h00, 2'b00, e, 0);
      waitIdle();

      e = '{data: 8'h01, has_par: 1, par: 1, len: LEN_PAR, gap: -1, aborted: 0};
      applyStimulus(8'h01, 2'b10, e, 1);
      s_data = 8'h80;
      e = '{data: 8'h80, has_par: 1, par: 1, len: LEN_PAR, gap: 1, aborted: 0};
      applyStimulus(8'h80, 2'b10, e, 0);
      waitIdle();

      e = '{data: 8'hFF, has_par: 0, par: 0, len: 10, gap: -1, aborted: 1};
      applyStimulus(8'hFF, 2'b00, e, 0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort tx", tx, 1);
      checkOutput("abort busy", busy, 0);
      checkOutput("abort s_ready", s_ready, 1);
      checkOutput("abort done", done, 0);
      reset = 1'b0;
      waitIdle();

      checkOutput("scoreboard empty", sb.size(), 0);
      checkOutput("done outside frame", stray_done, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
